// File: rtl/oled_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_frame_scheduler: frame-aligned pixel-source selector for OLED video.  |
// | Optional macro OLED_FRAME_SCHEDULER_BLANK_EN inserts a black frame per     |
// | switch.  Revision 1.0                                                      |
// +--------------------------------------------------------------------------+
module oled_frame_scheduler #(
  parameter int C_color_bits        = 16,
  parameter int C_sources           = 4,
  parameter int C_x_max             = 95,
  parameter int C_y_max             = 63,
  parameter int C_frames_per_source = 60
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [6:0]                        x,
  input  logic [5:0]                        y,
  input  logic                              next_pixel,
  input  logic [C_sources*C_color_bits-1:0] color_in,
  input  logic                              sel_next,
  input  logic                              auto_en,
  output logic [C_color_bits-1:0]           color,
  output logic [C_sources-1:0]              en,
  output logic [1:0]                        src,
  output logic                              frame_tick
);

  localparam logic [6:0]  C_X_LAST     = 7'(C_x_max);
  localparam logic [5:0]  C_Y_LAST     = 6'(C_y_max);
  localparam logic [1:0]  C_LAST_SRC   = 2'(C_sources - 1);
  localparam logic [15:0] C_LAST_FRAME = 16'(C_frames_per_source - 1);

  typedef enum logic [1:0] {
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
    ST_BLANK = 2'd2,
`endif
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  src_nxt;
  logic [15:0] frame_cnt, frame_cnt_nxt;
  logic        frame_end;
  logic        auto_hit;
  logic        go_switch;
  logic [1:0]  src_inc;
  logic        blanking;

  assign frame_end = next_pixel && (x == C_X_LAST) && (y == C_Y_LAST);
  assign auto_hit  = auto_en && (frame_cnt == C_LAST_FRAME);
  assign src_inc   = (src == C_LAST_SRC) ? 2'd0 : 2'(src + 2'd1);

`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
  assign blanking = (state == ST_BLANK);
`else
  assign blanking = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_RUN;
      src        <= 2'd0;
      frame_cnt  <= 16'd0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      src        <= src_nxt;
      frame_cnt  <= frame_cnt_nxt;
      frame_tick <= frame_end;
    end
  end

  // src only moves on frame-end cycles, so a frame is never split between sources.
  always_comb begin
    state_nxt     = state;
    src_nxt       = src;
    frame_cnt_nxt = auto_en ? frame_cnt : 16'd0;
    go_switch     = 1'b0;

    case (state)
      ST_RUN: begin
        if (frame_end) begin
          if (sel_next || auto_hit) begin
            go_switch = 1'b1;
          end else if (auto_en) begin
            frame_cnt_nxt = frame_cnt + 16'd1;
          end
        end else if (sel_next) begin
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_end) begin
          go_switch = 1'b1;
        end
      end
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
      ST_BLANK: begin
        if (frame_end) begin
          state_nxt     = ST_RUN;
          src_nxt       = src_inc;
          frame_cnt_nxt = 16'd0;
        end
      end
`endif
      default: state_nxt = ST_RUN;
    endcase

    if (go_switch) begin
      frame_cnt_nxt = 16'd0;
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
      state_nxt     = ST_BLANK;
`else
      state_nxt     = ST_RUN;
      src_nxt       = src_inc;
`endif
    end
  end

  always_comb begin
    en    = '0;
    color = '0;
    for (int k = 0; k < C_sources; k++) begin
      if (src == 2'(k)) begin
        en[k] = !blanking;
        if (!blanking) begin
          color = color_in[k*C_color_bits +: C_color_bits];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_oled_frame_scheduler: directed self-checking bench for the scheduler.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_oled_frame_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        next_pixel;
  logic [63:0] color_in;
  logic        sel_next;
  logic        auto_en;
  logic [15:0] color;
  logic [3:0]  en;
  logic [1:0]  src;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] auto_seq [8];

  always #5 clk = ~clk;

  oled_frame_scheduler #(
    .C_color_bits(16),
    .C_sources(4),
    .C_x_max(95),
    .C_y_max(63),
    .C_frames_per_source(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .x(x),
    .y(y),
    .next_pixel(next_pixel),
    .color_in(color_in),
    .sel_next(sel_next),
    .auto_en(auto_en),
    .color(color),
    .en(en),
    .src(src),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_color(input logic [3:0] e);
    case (e)
      4'b0001: return 16'h1111;
      4'b0010: return 16'h2222;
      4'b0100: return 16'h3333;
      4'b1000: return 16'h4444;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [1:0] exp_src(input logic [3:0] e);
    case (e)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Checks en/color, and src whenever a source is visibly active.
  task automatic expect_out(input string tag, input logic [3:0] e_en);
    check({tag, "_en"}, en, e_en);
    check({tag, "_color"}, color, exp_color(e_en));
    if (e_en != 4'b0000) check({tag, "_src"}, src, exp_src(e_en));
  endtask

  task automatic pixel(input logic [6:0] px, input logic [5:0] py, input logic sel);
    x = px; y = py; next_pixel = 1'b1; sel_next = sel;
    step();
    next_pixel = 1'b0; sel_next = 1'b0;
  endtask

  task automatic frame_end(input logic sel);
    x = 7'd95; y = 6'd63; next_pixel = 1'b1; sel_next = sel;
    step();
    next_pixel = 1'b0; sel_next = 1'b0; x = 7'd0; y = 6'd0;
    check("tick_hi", frame_tick, 1);
    step();
    check("tick_lo", frame_tick, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; x = '0; y = '0; next_pixel = 1'b0; sel_next = 1'b0; auto_en = 1'b0;
    color_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
    auto_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
`else
    auto_seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
`endif

    // Reset state
    step();
    expect_out("rst", 4'b0001);
    check("rst_tick", frame_tick, 0);
    step();
    rstn = 1'b1;

    // Three plain frames on source 0
    for (int f = 0; f < 3; f++) begin
      pixel(7'd40, 6'd20, 1'b0);
      frame_end(1'b0);
      expect_out("idle", 4'b0001);
    end

    // Near-frame-end pixels must not tick
    pixel(7'd95, 6'd62, 1'b0);
    check("nfe_row", frame_tick, 0);
    x = 7'd95; y = 6'd63; next_pixel = 1'b0;
    step();
    check("nfe_nopix", frame_tick, 0);

    // Manual switch mid-frame is deferred to the frame end
    pixel(7'd10, 6'd5, 1'b1);
    expect_out("pend", 4'b0001);
    pixel(7'd20, 6'd5, 1'b1);
    pixel(7'd94, 6'd63, 1'b0);
    expect_out("pend2", 4'b0001);
    frame_end(1'b0);
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
    expect_out("blank", 4'b0000);
    pixel(7'd5, 6'd5, 1'b1);
    frame_end(1'b0);
    expect_out("post_blank", 4'b0010);
`else
    expect_out("manual", 4'b0010);
`endif
    frame_end(1'b0);
    expect_out("manual_hold", 4'b0010);

    // Auto rotation every two frames, with wrap
    do_reset();
    auto_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      frame_end(1'b0);
      expect_out("auto", auto_seq[f]);
    end

    // Manual and auto trigger on the same frame end
    do_reset();
    frame_end(1'b0);
    expect_out("both_pre", 4'b0001);
    frame_end(1'b1);
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
    expect_out("both_blank", 4'b0000);
    frame_end(1'b0);
`endif
    expect_out("both", 4'b0010);

    // Dropping auto_en clears the frame counter
    frame_end(1'b0);
    expect_out("cnt_a", 4'b0010);
    auto_en = 1'b0;
    step();
    auto_en = 1'b1;
    frame_end(1'b0);
    expect_out("cnt_clr", 4'b0010);
    frame_end(1'b0);
`ifdef OLED_FRAME_SCHEDULER_BLANK_EN
    expect_out("cnt_sw", 4'b0000);
`else
    expect_out("cnt_sw", 4'b0100);
`endif
    auto_en = 1'b0;

    // Reset with a pending request discards it
    do_reset();
    pixel(7'd10, 6'd5, 1'b1);
    expect_out("pend_rst_pre", 4'b0001);
    rstn = 1'b0;
    #1;
    check("rst_src", src, 0);
    check("rst_tick2", frame_tick, 0);
    step();
    rstn = 1'b1;
    frame_end(1'b0);
    expect_out("pend_rst", 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
